// File: rtl/mmm_pkg.sv
// Shared definitions for the radix-4 Montgomery PE chain: the clogb2 width
// helper, geometry functions (words per operand, passes, slots per pass,
// total slots), the default-configuration geometry and the scheduler state
// encoding. Used by the scheduler, its interface and the PE array top level.
package mmm_pkg;

  localparam int K_DEF     = 1024;  // operand width, bits
  localparam int W_DEF     = 16;    // word width, bits
  localparam int P_DEF     = 8;     // PEs in chain
  localparam int LAG_DEF   = 2;     // word-slot offset between adjacent PEs
  localparam int TSLOT_DEF = 7;     // clock cycles per word slot

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clogb2(input int value);
    int bits;
    bits = 1;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

  function automatic int calc_nw(input int k, input int w);
    return k / w;
  endfunction

  // One radix-4 digit (2 bits of X) per PE per pass.
  function automatic int calc_npass(input int k, input int p);
    return (k / 2 + p - 1) / p;
  endfunction

  // A pass lasts at least LAG*P slots so that PE P-1's word 0 has come
  // around before PE0 needs it as feedback.
  function automatic int calc_pass_slots(input int nw, input int lag, input int p);
    return (nw > lag * p) ? nw : lag * p;
  endfunction

  function automatic int calc_t_total(input int npass, input int pass_slots,
                                      input int nw, input int lag, input int p);
    return (npass - 1) * pass_slots + nw + lag * (p - 1);
  endfunction

  localparam int NW         = calc_nw(K_DEF, W_DEF);
  localparam int NPASS      = calc_npass(K_DEF, P_DEF);
  localparam int PASS_SLOTS = calc_pass_slots(NW, LAG_DEF, P_DEF);
  localparam int T_TOTAL    = calc_t_total(NPASS, PASS_SLOTS, NW, LAG_DEF, P_DEF);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    FSUB  = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mmm_pe_scheduler_if.sv
// Command and PE-array control bundle of the PE chain scheduler.
//   start      command request              busy/done   command status
//   rd_en      operand read strobe          rd_addr     word index for PE0
//   pass_idx   current X digit group        first_word  PE0 clears carry
//   pe_en      per-PE slot enables          fb_push/pop feedback FIFO control
// master: the scheduler. slave: command source / PE array side.
// K, W and P must match the parameters of the connected scheduler.
interface mmm_pe_scheduler_if
  import mmm_pkg::*;
#(
  parameter int K = K_DEF,
  parameter int W = W_DEF,
  parameter int P = P_DEF
);
  localparam int AW  = clogb2(calc_nw(K, W));
  localparam int NPW = clogb2(calc_npass(K, P));

  logic           start;
  logic           busy;
  logic           done;
  logic           rd_en;
  logic [AW-1:0]  rd_addr;
  logic [NPW-1:0] pass_idx;
  logic           first_word;
  logic [P-1:0]   pe_en;
  logic           fb_push;
  logic           fb_pop;

  modport master (
    input  start,
    output busy, done, rd_en, rd_addr, pass_idx, first_word, pe_en, fb_push, fb_pop
  );

  modport slave (
    output start,
    input  busy, done, rd_en, rd_addr, pass_idx, first_word, pe_en, fb_push, fb_pop
  );
endinterface

// File: rtl/mmm_slot_timer.sv
// Word-slot timer: tcnt counts 0..TSLOT-1 and slot_tick marks the last cycle
// of each slot, so the slot counters advance on the same edge tcnt wraps.
// Ports: CLK clock, E_IN synchronous active-low reset, clr holds the count
// at 0 while the scheduler is idle, tcnt cycle-in-slot, slot_tick.
module mmm_slot_timer
  import mmm_pkg::*;
#(
  parameter int TSLOT = TSLOT_DEF
) (
  input  logic                       CLK,
  input  logic                       E_IN,
  input  logic                       clr,
  output logic [clogb2(TSLOT)-1:0]   tcnt,
  output logic                       slot_tick
);
  localparam int TW = clogb2(TSLOT);
  localparam logic [TW-1:0] T_LAST = TW'(TSLOT - 1);

  assign slot_tick = (tcnt == T_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK) begin
    if (!E_IN)                tcnt <= '0;
    else if (clr || slot_tick) tcnt <= '0;
    else                      tcnt <= tcnt + TW'(1);
  end
endmodule

// File: rtl/mmm_pe_scheduler.sv
// Sequencer for the radix-4 Montgomery PE chain. After an accepted start it
// walks pass n / word j / cycle-in-slot loops, issuing operand words to PE0,
// enabling each PE k exactly LAG*k slots behind PE0 and steering the
// feedback FIFO between PE P-1 and PE0.
// Ports: CLK clock, E_IN synchronous active-low reset, bus (master side of
// mmm_pe_scheduler_if) carrying start/busy/done and the PE array controls.
// Optional build macro MMM_FINAL_SUB_EN adds the FSUB phase, which re-walks
// the result words towards the final subtractor before done.
// Assumes P >= 2 and LAG >= 1.
module mmm_pe_scheduler
  import mmm_pkg::*;
#(
  parameter int K     = K_DEF,
  parameter int W     = W_DEF,
  parameter int P     = P_DEF,
  parameter int LAG   = LAG_DEF,
  parameter int TSLOT = TSLOT_DEF
) (
  input  logic                CLK,
  input  logic                E_IN,
  mmm_pe_scheduler_if.master  bus
);
  localparam int NW_L    = calc_nw(K, W);
  localparam int NPASS_L = calc_npass(K, P);
  localparam int PS_L    = calc_pass_slots(NW_L, LAG, P);
  localparam int DEPTH   = LAG * (P - 1);   // slots from PE0 to PE P-1
  localparam int JW      = clogb2(PS_L);
  localparam int NPW     = clogb2(NPASS_L);
  localparam int AW      = clogb2(NW_L);
  localparam int TW      = clogb2(TSLOT);

  localparam logic [JW-1:0]  J_PASS_END  = JW'(PS_L - 1);
  localparam logic [JW-1:0]  J_WORD_END  = JW'(NW_L - 1);
  localparam logic [JW-1:0]  J_DRAIN_END = JW'(DEPTH - 1);
  localparam logic [NPW-1:0] N_LAST      = NPW'(NPASS_L - 1);

  state_e           state_q, state_d;
  logic [JW-1:0]    j_q;      // slot within pass (RUN) / phase slot (DRAIN, FSUB)
  logic [NPW-1:0]   n_q;      // pass index, saturating
  logic [DEPTH-1:0] act_q;    // act_q[i]: PE0 issued a word i+1 slots ago
  logic [DEPTH-1:0] fwd_q;    // ...and that word belongs to a pass that feeds back
  logic [TW-1:0]    tcnt;
  logic             slot_tick;
  logic             first_cyc;
  logic             pe0_act;
  logic [DEPTH:0]   act_vec;
  logic [DEPTH:0]   fwd_vec;
  logic [P-1:0]     pe_en;

  mmm_slot_timer #(.TSLOT(TSLOT)) u_slot_timer (
    .CLK       (CLK),
    .E_IN      (E_IN),
    .clr       (state_q == IDLE || state_q == DONE),
    .tcnt      (tcnt),
    .slot_tick (slot_tick)
  );

  // Slots with j >= NW are stall slots: PE0 waits for feedback word 0.
  assign pe0_act   = (state_q == RUN) && (j_q <= J_WORD_END);
  assign first_cyc = (tcnt == '0);
  // Index d of these vectors describes PE0's activity d slots ago, which is
  // exactly what the PE sitting d slots down the chain is working on now.
  assign act_vec   = {act_q, pe0_act};
  assign fwd_vec   = {fwd_q, pe0_act && (n_q != N_LAST)};

  always_ff @(posedge CLK) begin
    if (!E_IN) begin
      state_q <= IDLE;
      j_q     <= '0;
      n_q     <= '0;
      act_q   <= '0;
      fwd_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE || state_q == DONE) begin
        j_q   <= '0;
        n_q   <= '0;
        act_q <= '0;
        fwd_q <= '0;
      end else if (slot_tick) begin
        act_q <= act_vec[DEPTH-1:0];
        fwd_q <= fwd_vec[DEPTH-1:0];
        if (state_d != state_q) begin
          j_q <= '0;                       // each phase counts its slots from 0
        end else if (state_q == RUN && j_q == J_PASS_END) begin
          j_q <= '0;
          if (n_q != N_LAST) n_q <= n_q + NPW'(1);
        end else begin
          j_q <= j_q + JW'(1);
        end
      end
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    pe_en          = '0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.rd_en      = pe0_act && first_cyc;
    bus.rd_addr    = pe0_act ? AW'(j_q) : '0;
    bus.pass_idx   = n_q;
    bus.first_word = pe0_act && (j_q == '0);
    bus.fb_push    = first_cyc && fwd_vec[DEPTH];
    bus.fb_pop     = pe0_act && first_cyc && (n_q != '0);

    for (int k = 0; k < P; k++) pe_en[k] = act_vec[k*LAG];

    unique case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (slot_tick && n_q == N_LAST && j_q == J_WORD_END) state_d = DRAIN;
      end
      DRAIN: begin
        bus.busy = 1'b1;
`ifdef MMM_FINAL_SUB_EN
        if (slot_tick && j_q == J_DRAIN_END) state_d = FSUB;
`else
        if (slot_tick && j_q == J_DRAIN_END) state_d = DONE;
`endif
      end
`ifdef MMM_FINAL_SUB_EN
      FSUB: begin
        // Result words stream out of the feedback FIFO to the final
        // subtractor; the PE chain stays idle.
        bus.busy    = 1'b1;
        bus.rd_en   = first_cyc;
        bus.rd_addr = AW'(j_q);
        bus.fb_pop  = first_cyc;
        if (slot_tick && j_q == J_WORD_END) state_d = DONE;
      end
`endif
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    bus.pe_en = pe_en;
  end
endmodule

// File: tb/tb_mmm_pe_scheduler.sv
// Scoreboard bench for mmm_pe_scheduler (K=64, W=16, P=4, LAG=2, TSLOT=7:
// 4 words, 8 passes, 8 slots per pass with 4 stall slots, 66 slots per op).
// The driver steps one cycle at a time; whenever a start is accepted by the
// reference model, the expected outputs of every cycle of that operation are
// pushed to exp_q. The monitor pops on the matching cycle and compares;
// cycles with no queued entry must show idle outputs.
module tb_mmm_pe_scheduler;
  localparam int K = 64, W = 16, P = 4, LAG = 2, TSLOT = 7;
  localparam int NW    = K / W;
  localparam int NPASS = (K / 2 + P - 1) / P;
  localparam int PS    = (NW > LAG * P) ? NW : LAG * P;
`ifdef MMM_FINAL_SUB_EN
  localparam int FSUB_SLOTS = NW;
`else
  localparam int FSUB_SLOTS = 0;
`endif
  localparam int T_SLOTS  = (NPASS - 1) * PS + NW + LAG * (P - 1) + FSUB_SLOTS;
  localparam int T_CYC    = T_SLOTS * TSLOT;
  localparam int FIFO_END = -FSUB_SLOTS;

  typedef struct {
    int   cyc;
    logic busy, done, rd_en, first_word, fb_push, fb_pop;
    logic [P-1:0] pe_en;
    int   rd_addr;
    int   pass_idx;
    bit   chk_pass;
  } exp_t;

  logic CLK;
  logic E_IN;
  int   cyc = 0;
  int   n_checks = 0, n_pass = 0;
  exp_t exp_q[$];
  int   free_cyc = 1;      // first cycle in which the model is IDLE
  int   pending_done = 0;
  int   exp_dones = 0, got_dones = 0;
  int   occ = 0, max_occ = 0;

  mmm_pe_scheduler_if #(.K(K), .W(W), .P(P)) bus ();

  mmm_pe_scheduler #(.K(K), .W(W), .P(P), .LAG(LAG), .TSLOT(TSLOT)) dut (
    .CLK  (CLK),
    .E_IN (E_IN),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic check(input string name, input int c, input logic [31:0] got,
                       input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, got, want);
  endtask

  // x = PE0 issue slot; valid when it names word j<NW of pass n<NPASS.
  function automatic bit issue_ok(input int x);
    if (x < 0) return 1'b0;
    return (x / PS < NPASS) && (x % PS < NW);
  endfunction

  task automatic push_run(input int c0);
    exp_t e;
    for (int s = 0; s < T_SLOTS; s++) begin
      for (int t = 0; t < TSLOT; t++) begin
        int  n, j, xl;
        bit  pe0;
        bit  fsub;
        e = '{default: 0};
        e.cyc  = c0 + 1 + s * TSLOT + t;
        e.busy = 1'b1;
        fsub   = (s >= T_SLOTS - FSUB_SLOTS);
        n = s / PS;
        j = s % PS;
        pe0 = !fsub && issue_ok(s);
        for (int k = 0; k < P; k++) e.pe_en[k] = !fsub && issue_ok(s - k * LAG);
        xl = s - (P - 1) * LAG;
        e.fb_push    = (t == 0) && !fsub && issue_ok(xl) && (xl / PS < NPASS - 1);
        e.first_word = pe0 && (j == 0);
        if (fsub) begin
          e.rd_en   = (t == 0);
          e.rd_addr = s - (T_SLOTS - FSUB_SLOTS);
          e.fb_pop  = (t == 0);
        end else begin
          e.rd_en    = pe0 && (t == 0);
          e.rd_addr  = j;
          e.pass_idx = n;
          e.chk_pass = pe0 && (t == 0);
          e.fb_pop   = pe0 && (t == 0) && (n > 0);
        end
        exp_q.push_back(e);
      end
    end
    e = '{default: 0};
    e.cyc  = c0 + 1 + T_CYC;
    e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  // Inputs driven here belong to cycle c and are sampled at the next edge.
  task automatic model_cycle(input int c, input logic st, input logic rn);
    if (!rn) begin
      while (exp_q.size() > 0 && exp_q[$].cyc > c) void'(exp_q.pop_back());
      if (pending_done > c) begin
        exp_dones--;
        pending_done = 0;
      end
      free_cyc = c + 1;
    end else if (st && c >= free_cyc) begin
      push_run(c);
      exp_dones++;
      pending_done = c + 1 + T_CYC;
      free_cyc     = pending_done + 1;
    end
  endtask

  task automatic drive_cycle(input logic st, input logic rn);
    @(posedge CLK);
    #1;
    bus.start = st;
    E_IN      = rn;
    model_cycle(cyc, st, rn);
  endtask

  // Monitor: compare against the queued record for this cycle, else idle.
  exp_t m_e;
  always @(negedge CLK) begin
    if (cyc >= 1) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) m_e = exp_q.pop_front();
      else m_e = '{default: 0};
      check("ctrl", cyc,
            32'({bus.busy, bus.done, bus.rd_en, bus.first_word, bus.fb_push, bus.fb_pop, bus.pe_en}),
            32'({m_e.busy, m_e.done, m_e.rd_en, m_e.first_word, m_e.fb_push, m_e.fb_pop, m_e.pe_en}));
      if (m_e.rd_en)    check("rd_addr", cyc, 32'(bus.rd_addr), 32'(m_e.rd_addr));
      if (m_e.chk_pass) check("pass_idx", cyc, 32'(bus.pass_idx), 32'(m_e.pass_idx));

      if (bus.fb_push === 1'b1) occ++;
      if (bus.fb_pop === 1'b1)  occ--;
      if (occ > max_occ) max_occ = occ;
      if (bus.done === 1'b1) begin
        got_dones++;
        check("fifo_balance", cyc, 32'(occ), 32'(FIFO_END));
        check("fifo_depth_ok", cyc, 32'(max_occ <= NW), 32'd1);
        occ = 0;
        max_occ = 0;
      end
      if (E_IN !== 1'b1) begin
        occ = 0;
        max_occ = 0;
      end
    end
  end

  initial begin
    int gap;
    int guard;
    E_IN      = 1'b0;
    bus.start = 1'b0;
    repeat (4) drive_cycle(1'b0, 1'b0);
    while (cyc < 9) drive_cycle(1'b0, 1'b1);

    // Run 1 accepted at cycle 10; random starts while busy must be ignored,
    // as must a start during the DONE cycle.
    drive_cycle(1'b1, 1'b1);
    while (cyc < 10 + T_CYC) drive_cycle(1'($urandom_range(0, 1)), 1'b1);
    drive_cycle(1'b1, 1'b1);
    repeat (6) drive_cycle(1'b0, 1'b1);

    // Run 2 cut short by a one-cycle reset, restarted right after it.
    drive_cycle(1'b1, 1'b1);
    gap = $urandom_range(20, 400);
    repeat (gap) drive_cycle(1'($urandom_range(0, 1)), 1'b1);
    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1);

    // Start held high through the whole run: the next accept lands on the
    // first IDLE cycle after DONE, giving a back-to-back run.
    repeat (T_CYC + 2) drive_cycle(1'b1, 1'b1);

    guard = 0;
    while (exp_q.size() > 0 && guard < 2 * T_CYC) begin
      drive_cycle(1'b0, 1'b1);
      guard++;
    end
    check("scoreboard_drained", cyc, 32'(exp_q.size()), 32'd0);
    repeat (3) drive_cycle(1'b0, 1'b1);
    check("done_count", cyc, 32'(got_dones), 32'(exp_dones));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
